// File: rtl/stack_access_ctrl_pkg.sv
// Shared definitions for the stack access controller: operation codes,
// FSM state encoding and the occupancy-counter width helper.
package stack_access_ctrl_pkg;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_CORE       = 3'd1;
    localparam logic [2:0] ST_BURST_PUSH = 3'd2;
    localparam logic [2:0] ST_BURST_POP  = 3'd3;
    localparam logic [2:0] ST_RESP       = 3'd4;

    typedef enum logic [2:0] {
        IDLE       = ST_IDLE,
        CORE       = ST_CORE,
        BURST_PUSH = ST_BURST_PUSH,
        BURST_POP  = ST_BURST_POP,
        RESP       = ST_RESP
    } state_t;

    // Occupancy must represent 0..depth inclusive.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/stack_ctx_buf.sv
// Interrupt context buffer: holds one CTX_WORDS x WIDTH context, loaded in
// parallel for a save or filled word by word during a restore, plus the
// word counter that walks a burst.
module stack_ctx_buf #(
    parameter int WIDTH     = 8,
    parameter int CTX_WORDS = 2,
    localparam int IW       = (CTX_WORDS > 1) ? $clog2(CTX_WORDS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic [CTX_WORDS*WIDTH-1:0] load_data,
    input  logic                       wr_en,
    input  logic [IW-1:0]              wr_idx,
    input  logic [WIDTH-1:0]           wr_word,
    input  logic [IW-1:0]              rd_idx,
    output logic [WIDTH-1:0]           rd_word,
    output logic [CTX_WORDS*WIDTH-1:0] ctx,
    input  logic                       cnt_clr,
    input  logic                       cnt_inc,
    output logic [IW-1:0]              cnt,
    output logic                       cnt_last
);

    logic [CTX_WORDS*WIDTH-1:0] ctx_q;
    logic [IW-1:0]              cnt_q;

    // Context storage: a parallel load wins over a single-word write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctx_q <= '0;
        end else if (load) begin
            ctx_q <= load_data;
        end else if (wr_en) begin
            ctx_q[int'(wr_idx)*WIDTH +: WIDTH] <= wr_word;
        end
    end

    // Burst word counter, 0..CTX_WORDS-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (cnt_inc && !cnt_last) begin
            cnt_q <= cnt_q + IW'(1);
        end
    end

    assign rd_word  = ctx_q[int'(rd_idx)*WIDTH +: WIDTH];
    assign ctx      = ctx_q;
    assign cnt      = cnt_q;
    assign cnt_last = (cnt_q == IW'(CTX_WORDS - 1));

endmodule

// File: rtl/stack_access_ctrl.sv
// Shares the hardware stack between the core (single-word push/pop) and the
// interrupt unit (atomic multi-word context save/restore). Sole driver of
// the stack strobes; also tracks stack occupancy.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   IDLE       | arbitrate, irq has fixed priority over core
//   CORE       | one-cycle access slot: core push/pop, or the dead cycle of
//              | a rejected irq request (keeps error latency equal to core)
//   BURST_PUSH | push context words 0..CTX_WORDS-1, one per cycle
//   BURST_POP  | pop CTX_WORDS words, first popped into the top slot
//   RESP       | one-cycle ack to the granted requester
module stack_access_ctrl
    import stack_access_ctrl_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int CTX_WORDS = 2,
    localparam int LW       = level_width(DEPTH),
    localparam int IW       = (CTX_WORDS > 1) ? $clog2(CTX_WORDS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       core_req,
    input  logic                       core_op,
    input  logic [WIDTH-1:0]           core_wdata,
    output logic                       core_ack,
    output logic [WIDTH-1:0]           core_rdata,
    output logic                       core_err,
    input  logic                       irq_req,
    input  logic                       irq_op,
    input  logic [CTX_WORDS*WIDTH-1:0] irq_wdata,
    output logic                       irq_ack,
    output logic [CTX_WORDS*WIDTH-1:0] irq_rdata,
    output logic                       irq_err,
    output logic                       stk_push,
    output logic                       stk_pop,
    output logic [WIDTH-1:0]           stk_din,
    input  logic [WIDTH-1:0]           stk_dout,
    input  logic                       stk_empty,
    input  logic                       stk_full,
    output logic                       busy,
    output logic [LW-1:0]              level
);

    state_t               state, state_nxt;
    logic                 grant_irq;
    logic                 op_q;
    logic                 err_q;
    logic [WIDTH-1:0]     core_rdata_q;
    logic [LW-1:0]        level_q;

    logic                 irq_reject;
    logic                 buf_load;
    logic                 buf_wr;
    logic                 cnt_clr;
    logic                 cnt_inc;
    logic [IW-1:0]        cnt;
    logic                 cnt_last;
    logic [IW-1:0]        wr_idx;
    logic [WIDTH-1:0]     buf_word;
    logic [CTX_WORDS*WIDTH-1:0] buf_ctx;

    // Space/data checks are done on the tracked level, so a burst can never
    // strobe an empty or full stack.
    assign irq_reject = (irq_op == OP_PUSH) ? ((DEPTH - int'(level_q)) < CTX_WORDS)
                                            : (int'(level_q) < CTX_WORDS);

    // Pops land in reverse slot order so save+restore returns the same vector.
    assign wr_idx = IW'(CTX_WORDS - 1) - cnt;

    stack_ctx_buf #(
        .WIDTH     (WIDTH),
        .CTX_WORDS (CTX_WORDS)
    ) u_ctx_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (buf_load),
        .load_data (irq_wdata),
        .wr_en     (buf_wr),
        .wr_idx    (wr_idx),
        .wr_word   (stk_dout),
        .rd_idx    (cnt),
        .rd_word   (buf_word),
        .ctx       (buf_ctx),
        .cnt_clr   (cnt_clr),
        .cnt_inc   (cnt_inc),
        .cnt       (cnt),
        .cnt_last  (cnt_last)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and stack strobes.
    always_comb begin
        state_nxt = state;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        stk_din   = '0;
        buf_load  = 1'b0;
        buf_wr    = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                if (irq_req) begin
                    if (irq_reject) begin
                        state_nxt = CORE;
                    end else if (irq_op == OP_PUSH) begin
                        buf_load  = 1'b1;
                        state_nxt = BURST_PUSH;
                    end else begin
                        state_nxt = BURST_POP;
                    end
                end else if (core_req) begin
                    state_nxt = CORE;
                end
            end
            CORE: begin
                if (!grant_irq) begin
                    if (core_op == OP_PUSH && !stk_full) begin
                        stk_push = 1'b1;
                        stk_din  = core_wdata;
                    end else if (core_op == OP_POP && !stk_empty) begin
                        stk_pop = 1'b1;
                    end
                end
                state_nxt = RESP;
            end
            BURST_PUSH: begin
                stk_push = 1'b1;
                stk_din  = buf_word;
                cnt_inc  = 1'b1;
                if (cnt_last) state_nxt = RESP;
            end
            BURST_POP: begin
                stk_pop = 1'b1;
                buf_wr  = 1'b1;
                cnt_inc = 1'b1;
                if (cnt_last) state_nxt = RESP;
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Grant bookkeeping and the core pop data latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_irq    <= 1'b0;
            op_q         <= OP_PUSH;
            err_q        <= 1'b0;
            core_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    core_rdata_q <= '0;
                    if (irq_req) begin
                        grant_irq <= 1'b1;
                        op_q      <= irq_op;
                        err_q     <= irq_reject;
                    end else if (core_req) begin
                        grant_irq <= 1'b0;
                        op_q      <= core_op;
                        err_q     <= 1'b0;
                    end
                end
                CORE: begin
                    if (!grant_irq) begin
                        err_q <= !(stk_push || stk_pop);
                        if (stk_pop) core_rdata_q <= stk_dout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Occupancy: follows the strobes, saturating at both ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= '0;
        end else if (stk_push && level_q != LW'(DEPTH)) begin
            level_q <= level_q + LW'(1);
        end else if (stk_pop && level_q != '0) begin
            level_q <= level_q - LW'(1);
        end
    end

    assign level      = level_q;
    assign busy       = (state != IDLE);
    assign core_ack   = (state == RESP) && !grant_irq;
    assign irq_ack    = (state == RESP) && grant_irq;
    assign core_err   = core_ack && err_q;
    assign irq_err    = irq_ack && err_q;
    assign core_rdata = core_ack ? core_rdata_q : '0;
    assign irq_rdata  = (irq_ack && op_q == OP_POP && !err_q) ? buf_ctx : '0;

endmodule

// File: tb/tb_stack_access_ctrl.sv
// Directed bench for stack_access_ctrl with a behavioural 16-deep stack
// attached; strobe activity is logged by a monitor on the falling edge.
module tb_stack_access_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int CTX   = 2;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int LIM   = 20;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   core_req = 1'b0;
    logic                   core_op = 1'b0;
    logic [WIDTH-1:0]       core_wdata = '0;
    logic                   core_ack;
    logic [WIDTH-1:0]       core_rdata;
    logic                   core_err;
    logic                   irq_req = 1'b0;
    logic                   irq_op = 1'b0;
    logic [CTX*WIDTH-1:0]   irq_wdata = '0;
    logic                   irq_ack;
    logic [CTX*WIDTH-1:0]   irq_rdata;
    logic                   irq_err;
    logic                   stk_push;
    logic                   stk_pop;
    logic [WIDTH-1:0]       stk_din;
    logic [WIDTH-1:0]       stk_dout;
    logic                   stk_empty;
    logic                   stk_full;
    logic                   busy;
    logic [LW-1:0]          level;

    int tests = 0;
    int fails = 0;

    stack_access_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CTX_WORDS(CTX)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_op(core_op), .core_wdata(core_wdata),
        .core_ack(core_ack), .core_rdata(core_rdata), .core_err(core_err),
        .irq_req(irq_req), .irq_op(irq_op), .irq_wdata(irq_wdata),
        .irq_ack(irq_ack), .irq_rdata(irq_rdata), .irq_err(irq_err),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din),
        .stk_dout(stk_dout), .stk_empty(stk_empty), .stk_full(stk_full),
        .busy(busy), .level(level)
    );

    always #5 clk = ~clk;

    // Behavioural stack, emptied by the same reset.
    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [4:0]       sp;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sp <= '0;
        end else if (stk_push && sp != 5'd16) begin
            mem[sp[3:0]] <= stk_din;
            sp <= sp + 5'd1;
        end else if (stk_pop && sp != 5'd0) begin
            sp <= sp - 5'd1;
        end
    end
    assign stk_empty = (sp == 5'd0);
    assign stk_full  = (sp == 5'd16);
    assign stk_dout  = (stk_pop && sp != 5'd0) ? mem[sp[3:0] - 4'd1] : '0;

    // Strobe / ack monitor.
    logic [WIDTH-1:0] pushed [$];
    int push_cnt = 0;
    int pop_cnt  = 0;
    int dual_cnt = 0;
    int irq_ack_cnt = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (stk_push) begin
                push_cnt++;
                pushed.push_back(stk_din);
            end
            if (stk_pop) pop_cnt++;
            if (stk_push && stk_pop) dual_cnt++;
            if (irq_ack) irq_ack_cnt++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic core_txn(input logic op, input logic [WIDTH-1:0] wd,
                            output int lat, output logic [WIDTH-1:0] rd, output logic err);
        core_req = 1'b1; core_op = op; core_wdata = wd; lat = 0;
        while (!core_ack && lat < LIM) begin
            tick();
            lat++;
        end
        rd = core_rdata; err = core_err;
        core_req = 1'b0;
        tick();
    endtask

    task automatic irq_txn(input logic op, input logic [CTX*WIDTH-1:0] wd,
                           output int lat, output logic [CTX*WIDTH-1:0] rd, output logic err);
        irq_req = 1'b1; irq_op = op; irq_wdata = wd; lat = 0;
        while (!irq_ack && lat < LIM) begin
            tick();
            lat++;
        end
        rd = irq_rdata; err = irq_err;
        irq_req = 1'b0;
        tick();
    endtask

    initial begin
        int lat;
        int lat2;
        int pc;
        int ac;
        logic [WIDTH-1:0] rd;
        logic [CTX*WIDTH-1:0] ird;
        logic err;

        // Reset state
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_acks", {core_ack, irq_ack, core_err, irq_err}, 0);
        chk("rst_strobes", {stk_push, stk_pop}, 0);
        rst = 1'b0;
        tick();
        chk("idle_level", level, 0);
        chk("idle_rdata", {core_rdata, irq_rdata}, 0);

        // 1: push A5, pop it back
        core_txn(1'b0, 8'hA5, lat, rd, err);
        chk("t1_push_lat", lat, 2);
        chk("t1_push_err", err, 0);
        chk("t1_level1", level, 1);
        core_txn(1'b1, 8'h00, lat, rd, err);
        chk("t1_pop_lat", lat, 2);
        chk("t1_pop_rdata", rd, 8'hA5);
        chk("t1_pop_err", err, 0);
        chk("t1_level0", level, 0);

        // 2: pop on empty
        pc = pop_cnt;
        core_txn(1'b1, 8'h00, lat, rd, err);
        chk("t2_lat", lat, 2);
        chk("t2_err", err, 1);
        chk("t2_rdata", rd, 0);
        chk("t2_no_pop", pop_cnt, pc);
        chk("t2_level", level, 0);

        // 3: irq save, core push/pop, irq restore
        pushed.delete();
        irq_txn(1'b0, 16'h3412, lat, ird, err);
        chk("t3_save_lat", lat, 3);
        chk("t3_save_err", err, 0);
        chk("t3_push_n", pushed.size(), 2);
        if (pushed.size() == 2) begin
            chk("t3_push0", pushed[0], 8'h12);
            chk("t3_push1", pushed[1], 8'h34);
        end
        chk("t3_level2", level, 2);
        core_txn(1'b0, 8'h77, lat, rd, err);
        chk("t3_level3", level, 3);
        core_txn(1'b1, 8'h00, lat, rd, err);
        chk("t3_pop_rdata", rd, 8'h77);
        irq_txn(1'b1, 16'h0000, lat, ird, err);
        chk("t3_rest_lat", lat, 3);
        chk("t3_rest_rdata", ird, 16'h3412);
        chk("t3_rest_err", err, 0);
        chk("t3_level0", level, 0);

        // 4: simultaneous requests, irq wins, core follows
        pushed.delete();
        irq_req = 1'b1; irq_op = 1'b0; irq_wdata = 16'hCDAB;
        core_req = 1'b1; core_op = 1'b0; core_wdata = 8'h55;
        lat = 0;
        while (!irq_ack && lat < LIM) begin
            tick();
            lat++;
        end
        chk("t4_irq_lat", lat, 3);
        chk("t4_core_wait", core_ack, 0);
        irq_req = 1'b0;
        lat2 = 0;
        while (!core_ack && lat2 < LIM) begin
            tick();
            lat2++;
        end
        chk("t4_core_lat", lat2, 3);
        chk("t4_core_err", core_err, 0);
        core_req = 1'b0;
        tick();
        chk("t4_push_n", pushed.size(), 3);
        if (pushed.size() == 3) begin
            chk("t4_order", {pushed[0], pushed[1], pushed[2]}, 24'hABCD55);
        end
        chk("t4_level", level, 3);
        core_txn(1'b1, 8'h00, lat, rd, err);
        chk("t4_core_pop", rd, 8'h55);
        irq_txn(1'b1, 16'h0000, lat, ird, err);
        chk("t4_restore", ird, 16'hCDAB);
        chk("t4_level0", level, 0);

        // 5: near-full save rejected, fill to full, overflow
        for (int i = 0; i < 15; i++) core_txn(1'b0, 8'(i), lat, rd, err);
        chk("t5_level15", level, 15);
        pc = push_cnt;
        irq_txn(1'b0, 16'hFFEE, lat, ird, err);
        chk("t5_save_lat", lat, 2);
        chk("t5_save_err", err, 1);
        chk("t5_no_strobe", push_cnt, pc);
        core_txn(1'b0, 8'hC3, lat, rd, err);
        chk("t5_push_ok", err, 0);
        chk("t5_level16", level, 16);
        core_txn(1'b0, 8'hC4, lat, rd, err);
        chk("t5_overflow", err, 1);
        chk("t5_level_sat", level, 16);

        // 6: reset in the middle of a burst
        rst = 1'b1; tick(); rst = 1'b0; tick();
        chk("t6_level0", level, 0);
        ac = irq_ack_cnt;
        irq_req = 1'b1; irq_op = 1'b0; irq_wdata = 16'h2211;
        tick();
        tick();
        chk("t6_in_burst", {busy, stk_push}, 2'b11);
        rst = 1'b1;
        irq_req = 1'b0;
        tick();
        chk("t6_outs", {busy, stk_push, stk_pop, core_ack, irq_ack, core_err, irq_err}, 0);
        chk("t6_rdata", {core_rdata, irq_rdata}, 0);
        chk("t6_level", level, 0);
        rst = 1'b0;
        tick(); tick();
        chk("t6_no_ack", irq_ack_cnt, ac);
        core_txn(1'b0, 8'h99, lat, rd, err);
        chk("t6_push_lat", lat, 2);
        chk("t6_push_err", err, 0);
        chk("t6_level1", level, 1);

        chk("no_dual_strobe", dual_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
